// File: rtl/usb_system_sysid_checker_pkg.sv
// Shared definitions for the sysid checker: bus widths, word addresses, FSM states.
package usb_system_sysid_checker_pkg;

    localparam int unsigned SYSID_DATA_W  = 32;
    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_ID,
        ST_WAIT_ID,
        ST_REQ_TS,
        ST_WAIT_TS,
        ST_FIN
    } state_t;

endpackage

// File: rtl/usb_system_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker (master) and the sysid slave.
interface usb_system_sysid_checker_if;
    import usb_system_sysid_checker_pkg::*;

    logic                    av_address;
    logic                    av_read;
    logic                    av_waitrequest;
    logic [SYSID_DATA_W-1:0] av_readdata;
    logic                    av_readdatavalid;

    modport master (
        output av_address, av_read,
        input  av_waitrequest, av_readdata, av_readdatavalid
    );

    modport slave (
        input  av_address, av_read,
        output av_waitrequest, av_readdata, av_readdatavalid
    );

endinterface

// File: rtl/usb_system_sysid_checker.sv
// Boot-time system-ID checker: reads ID and build timestamp from the sysid
// slave, compares against expected values, reports pass/fail/timeout.
module usb_system_sysid_checker
    import usb_system_sysid_checker_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1430756268,
    parameter int unsigned             TIMEOUT_CYCLES     = 1024,
    parameter bit                      AUTO_START         = 1'b1,
    parameter bit                      USE_READDATAVALID  = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    usb_system_sysid_checker_if.master    av,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timeout,
    output logic [SYSID_DATA_W-1:0]       id_value,
    output logic [SYSID_DATA_W-1:0]       ts_value
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             auto_pend;

    logic active;
    logic id_phase;
    logic rd_accept;
    logic expire;
    logic capture;
    logic go_wait;
    logic give_up;

    // Decode of the current read phase: capture, move to wait, or give up.
    // A capture on the expiry cycle wins; an accept on the expiry cycle with
    // readdatavalid still outstanding cannot complete in time, so it gives up.
    always_comb begin
        active    = state inside {ST_REQ_ID, ST_WAIT_ID, ST_REQ_TS, ST_WAIT_TS};
        id_phase  = state inside {ST_REQ_ID, ST_WAIT_ID};
        rd_accept = av.av_read && !av.av_waitrequest;
        expire    = (cnt == CNT_LAST);
        if (USE_READDATAVALID) begin
            capture = (state inside {ST_WAIT_ID, ST_WAIT_TS}) && av.av_readdatavalid;
            go_wait = rd_accept && !expire;
        end else begin
            capture = rd_accept;
            go_wait = 1'b0;
        end
        give_up = active && !capture && !go_wait && expire;
    end

    // Check sequencer with registered bus and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            auto_pend     <= AUTO_START;
            av.av_read    <= 1'b0;
            av.av_address <= SYSID_ADDR_ID;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout       <= 1'b0;
            id_value      <= '0;
            ts_value      <= '0;
        end else begin
            auto_pend <= 1'b0;
            done      <= 1'b0;
            if (capture && id_phase) begin
                id_value      <= av.av_readdata;
                state         <= ST_REQ_TS;
                av.av_read    <= 1'b1;
                av.av_address <= SYSID_ADDR_TS;
                cnt           <= '0;
            end else if (capture) begin
                ts_value   <= av.av_readdata;
                id_ok      <= (id_value == EXPECTED_ID);
                ts_ok      <= (av.av_readdata == EXPECTED_TIMESTAMP);
                state      <= ST_FIN;
                done       <= 1'b1;
                av.av_read <= 1'b0;
            end else if (give_up) begin
                timeout    <= 1'b1;
                id_ok      <= 1'b0;
                ts_ok      <= 1'b0;
                state      <= ST_FIN;
                done       <= 1'b1;
                av.av_read <= 1'b0;
            end else if (go_wait) begin
                av.av_read <= 1'b0;
                cnt        <= cnt + CNT_W'(1);
                state      <= id_phase ? ST_WAIT_ID : ST_WAIT_TS;
            end else if (active) begin
                cnt <= cnt + CNT_W'(1);
            end else if (state == ST_FIN) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (start || auto_pend) begin
                state         <= ST_REQ_ID;
                busy          <= 1'b1;
                av.av_read    <= 1'b1;
                av.av_address <= SYSID_ADDR_ID;
                cnt           <= '0;
                id_ok         <= 1'b0;
                ts_ok         <= 1'b0;
                timeout       <= 1'b0;
                id_value      <= '0;
                ts_value      <= '0;
            end
        end
    end

endmodule
